// File: rtl/switch_pkg.sv
// ============================================================================
// Module      : switch_pkg
// Description : Shared types and constants for the 4-port switch fabric.
//               NUM_PORTS / PORT_W size the per-port vectors, egress_state_e
//               is the egress scheduler state, beat_t is one payload beat.
//               lowest_set_idx() converts a grant vector to a port index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int PORT_W     = 2;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } egress_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  sop;
    logic                  eop;
  } beat_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [PORT_W-1:0] lowest_set_idx(input logic [NUM_PORTS-1:0] v);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (v[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter.sv
// ============================================================================
// Module      : arbiter
// Description : Round-robin arbiter with a registered one-hot grant.
//               The search starts at the pointer; the pointer moves to one
//               past the winner, and only on cycles that issue a grant.
//               N must be a power of two (the index wraps naturally).
// Ports       : clk, rst_n (async, active-low)
//               req   [N-1:0] in  : request vector
//               grant [N-1:0] out : registered one-hot grant (0 if no req)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + PTR_W'(k);
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant_d[idx]   = 1'b1;
        ptr_d          = idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

endmodule

`default_nettype wire

// File: rtl/egress_port.sv
// ============================================================================
// Module      : egress_port
// Description : Per-output-port packet scheduler. Arbitrates packet starts
//               from the four ingress heads aimed at PORT_ID, locks the
//               winner for the whole packet and streams its beats through a
//               registered valid/ready output stage.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_sop/in_eop [3:0] : ingress head status
//               in_dest [7:0]                 : 2-bit destination per port
//               in_data [4*DATA_W-1:0]        : head payload per port
//               in_ready [3:0]                : pop strobe (at most one set)
//               out_valid/out_data/out_sop/out_eop, out_ready : egress link
//               pkt_cnt, beat_cnt [31:0]      : only with EGRESS_STATS_EN
// Config      : `define EGRESS_STATS_EN adds the egress packet/beat counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module egress_port
  import switch_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [PORT_W-1:0] PORT_ID = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS-1:0]        in_sop,
  input  logic [NUM_PORTS-1:0]        in_eop,
  input  logic [NUM_PORTS*PORT_W-1:0] in_dest,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  input  logic                        out_ready
`ifdef EGRESS_STATS_EN
  ,
  output logic [31:0]                 pkt_cnt,
  output logic [31:0]                 beat_cnt
`endif
);

  logic [NUM_PORTS-1:0] req, req_arb, grant, grant_live;
  logic [DATA_W-1:0]    data_arr [NUM_PORTS];

  egress_state_e        state_q, state_d;
  logic [PORT_W-1:0]    sel_q, sel_d;
  logic                 xfer;

  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
    assign req[i]      = in_valid[i] & in_sop[i] & (in_dest[PORT_W*i +: PORT_W] == PORT_ID);
    assign data_arr[i] = in_data[DATA_W*i +: DATA_W];
  end

  // Requests only reach the arbiter in IDLE, so its grant is non-zero only
  // in the cycle right after IDLE.
  assign req_arb = (state_q == IDLE) ? req : '0;

  arbiter #(.N(NUM_PORTS)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_arb),
    .grant (grant)
  );

  // The grant reflects last cycle's requests; an ingress that dropped its
  // SOP head since then is treated as withdrawn.
  assign grant_live = grant & req;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    in_ready = '0;
    xfer     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (|grant_live) begin
          sel_d   = lowest_set_idx(grant_live);
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        in_ready[sel_q] = !out_valid_q | out_ready;
        xfer            = in_valid[sel_q] & in_ready[sel_q];
        if (xfer && in_eop[sel_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_sop_d   = in_sop[sel_q];
      out_eop_d   = in_eop[sel_q];
      out_data_d  = data_arr[sel_q];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_data  = out_data_q;

`ifdef EGRESS_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (out_valid_q && out_ready) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (out_eop_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_egress_port.sv
// ============================================================================
// Module      : tb_egress_port
// Description : Self-checking bench for egress_port. Ingress queues and the
//               egress sink live in the bench; a packet-level reference
//               model predicts pops and the egress register every cycle.
//               Stats checks compile only with EGRESS_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_egress_port;

  localparam int         DW  = 32;
  localparam logic [1:0] PID = 2'd0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid, in_sop, in_eop, in_ready;
  logic [7:0]    in_dest;
  logic [4*DW-1:0] in_data;
  logic          out_valid, out_sop, out_eop, out_ready;
  logic [DW-1:0] out_data;
`ifdef EGRESS_STATS_EN
  logic [31:0]   pkt_cnt, beat_cnt;
`endif

  always #5 clk = ~clk;

  egress_port #(.DATA_W(DW), .PORT_ID(PID)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_ready (out_ready)
`ifdef EGRESS_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .beat_cnt  (beat_cnt)
`endif
  );

  typedef struct {logic [31:0] d; logic sop; logic eop; logic [1:0] dest;} ib_t;
  typedef struct {int c; int port; logic [31:0] d;} pop_t;
  typedef struct {int c; logic [31:0] d; logic sop; logic eop;} hs_t;

  ib_t  iq [4][$];
  pop_t pops[$];
  hs_t  hs[$];
  bit   hold [4];
  bit   tb_ordy;
  int   checks, errors, cyc;

  // reference model state
  int          m_stage, m_cand, m_sel, m_ptr;
  logic        m_ov, m_os, m_oe;
  logic [31:0] m_od;
  logic        p_valid, p_ready, p_sop, p_eop;
  logic [31:0] p_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rrpick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic logic [31:0] beat_val(input int tag, input int port, input int k);
    return 32'(tag * 256 + port * 16 + k);
  endfunction

  task automatic send(input int port, input int nb, input logic [1:0] dest, input int tag);
    ib_t b;
    for (int k = 0; k < nb; k++) begin
      b.d = beat_val(tag, port, k); b.sop = (k == 0); b.eop = (k == nb - 1); b.dest = dest;
      iq[port].push_back(b);
    end
  endtask

  task automatic present();
    for (int i = 0; i < 4; i++) begin
      if (iq[i].size() != 0 && !hold[i]) begin
        in_valid[i] = 1'b1; in_sop[i] = iq[i][0].sop; in_eop[i] = iq[i][0].eop;
        in_dest[2*i +: 2] = iq[i][0].dest; in_data[DW*i +: DW] = iq[i][0].d;
      end else begin
        in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
        in_dest[2*i +: 2] = 2'd0; in_data[DW*i +: DW] = '0;
      end
    end
    out_ready = tb_ordy;
  endtask

  // Per-cycle compare and model step, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] r, er;
    logic       xf;
    cyc++;
    if (!rst_n) begin
      m_stage = 0; m_ptr = 0; m_ov = 1'b0; m_os = 1'b0; m_oe = 1'b0; m_od = '0;
      p_valid = 1'b0;
      present();
    end else begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      if (m_ov) begin
        chk("out_data", {32'd0, out_data}, {32'd0, m_od});
        chk("out_sop_eop", {62'd0, out_sop, out_eop}, {62'd0, m_os, m_oe});
      end
      if (p_valid && !p_ready)
        chk("stall_hold", {30'd0, out_data, out_sop, out_eop}, {30'd0, p_data, p_sop, p_eop});
      present();
      #1;
      for (int i = 0; i < 4; i++) r[i] = in_valid[i] & in_sop[i] & (in_dest[2*i +: 2] == PID);
      er = '0; xf = 1'b0;
      if (m_stage == 2) er[m_sel] = !m_ov | out_ready;
      chk("in_ready", {60'd0, in_ready}, {60'd0, er});
      p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_sop = out_sop; p_eop = out_eop;
      if (out_valid && out_ready) hs.push_back('{cyc, out_data, out_sop, out_eop});
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          pops.push_back('{cyc, i, iq[i][0].d});
          void'(iq[i].pop_front());
        end
      end
      case (m_stage)
        0: if (r != 0) begin m_cand = rrpick(r, m_ptr); m_ptr = (m_cand + 1) % 4; m_stage = 1; end
        1: if (r[m_cand]) begin m_sel = m_cand; m_stage = 2; end else m_stage = 0;
        default: begin
          xf = in_valid[m_sel] && er[m_sel];
          if (xf && in_eop[m_sel]) m_stage = 0;
        end
      endcase
      if (xf) begin
        m_ov = 1'b1; m_od = in_data[DW*m_sel +: DW]; m_os = in_sop[m_sel]; m_oe = in_eop[m_sel];
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    pops.delete(); hs.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin iq[i].delete(); hold[i] = 1'b0; end
    tb_ordy = 1'b1;
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_drain(input logic [3:0] mask, input int budget);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      @(posedge clk); n++;
      busy = (m_stage != 0) || out_valid;
      for (int i = 0; i < 4; i++) if (mask[i] && iq[i].size() != 0) busy = 1'b1;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c = 0;
    while (pops.size() < n && c < budget) begin @(posedge clk); c++; end
    if (pops.size() < n) begin
      checks++; errors++;
      $display("FAIL pop_timeout: got %0d pops, required %0d", pops.size(), n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, last1, first0;
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; tb_ordy = 1'b1;
    in_valid = '0; in_sop = '0; in_eop = '0; in_dest = '0; in_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) hold[i] = 1'b0;

    // reset values
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_framing", {62'd0, out_sop, out_eop}, 64'd0);
    chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    // single 3-beat packet from port 2
    @(posedge clk); t0 = cyc + 1;
    send(2, 3, PID, 1);
    wait_drain(4'b0100, 60);
    chk("single_pop_count", 64'(pops.size()), 64'd3);
    chk("single_hs_count", 64'(hs.size()), 64'd3);
    if (pops.size() >= 1) begin
      chk("single_first_pop_cycle", 64'(pops[0].c), 64'(t0 + 2));
      chk("single_pop_port", 64'(pops[0].port), 64'd2);
    end
    if (hs.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("single_out_cycle", 64'(hs[k].c), 64'(t0 + 3 + k));
        chk("single_out_data", {32'd0, hs[k].d}, {32'd0, beat_val(1, 2, k)});
        chk("single_out_framing", {62'd0, hs[k].sop, hs[k].eop}, {62'd0, k == 0, k == 2});
      end
    end

    // contention: ports 0..3 each 2-beat, then port 0 again
    do_reset();
    @(posedge clk);
    send(0, 2, PID, 10); send(1, 2, PID, 11); send(2, 2, PID, 12); send(3, 2, PID, 13);
    send(0, 2, PID, 14);
    wait_drain(4'hF, 120);
    chk("cont_pop_count", 64'(pops.size()), 64'd10);
    if (pops.size() >= 10) begin
      for (int k = 0; k < 5; k++) begin
        chk("cont_order", 64'(pops[2*k].port), 64'(k % 4));
        chk("cont_second_beat_same_port", 64'(pops[2*k+1].port), 64'(k % 4));
      end
      for (int k = 0; k < 4; k++)
        chk("cont_gap", 64'(pops[2*k+2].c - pops[2*k+1].c), 64'd3);
    end

    // backpressure: 4-cycle out_ready low mid-packet
    clear_logs();
    @(posedge clk);
    send(1, 6, PID, 20);
    wait_pops(2, 30);
    @(posedge clk); tb_ordy = 1'b0;
    repeat (4) @(posedge clk);
    tb_ordy = 1'b1;
    wait_drain(4'b0010, 60);
    chk("bp_pop_count", 64'(pops.size()), 64'd6);
    chk("bp_hs_count", 64'(hs.size()), 64'd6);
    if (hs.size() >= 6)
      for (int k = 0; k < 6; k++) chk("bp_out_data", {32'd0, hs[k].d}, {32'd0, beat_val(20, 1, k)});

    // lock: port 0 SOP during port 1 packet; port 2 SOP to another port
    clear_logs();
    @(posedge clk);
    send(1, 4, PID, 30);
    wait_pops(1, 30);
    @(posedge clk); hold[1] = 1'b1;
    send(0, 2, PID, 31);
    send(2, 2, 2'd3, 32);
    repeat (3) @(posedge clk);
    hold[1] = 1'b0;
    wait_drain(4'b0011, 80);
    last1 = -1; first0 = -1;
    foreach (pops[k]) begin
      if (pops[k].port == 1) last1 = pops[k].c;
      if (pops[k].port == 0 && first0 < 0) first0 = pops[k].c;
    end
    chk("lock_next_after_eop", 64'(first0 - last1), 64'd3);
    chk("mismatch_never_popped", 64'(iq[2].size()), 64'd2);
    iq[2].delete();

    // withdrawal: SOP drops during ARB
    clear_logs();
    @(posedge clk);
    send(3, 1, PID, 40);
    @(posedge clk); hold[3] = 1'b1;
    repeat (4) @(posedge clk);
    chk("withdraw_no_pop", 64'(pops.size()), 64'd0);
    hold[3] = 1'b0;
    wait_drain(4'b1000, 30);
    chk("withdraw_retry_pop", 64'(pops.size()), 64'd1);

    // reset mid-XFER
    clear_logs();
    @(posedge clk);
    send(0, 5, PID, 50);
    wait_pops(2, 30);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {60'd0, in_ready}, 64'd0);
    for (int i = 0; i < 4; i++) iq[i].delete();
    @(posedge clk); #3 rst_n = 1'b1;
    clear_logs();
    @(posedge clk); t0 = cyc + 1;
    send(0, 1, PID, 51);
    wait_drain(4'b0001, 30);
    chk("post_rst_first_pop", (pops.size() > 0) ? 64'(pops[0].c) : 64'd0, 64'(t0 + 2));

`ifdef EGRESS_STATS_EN
    do_reset();
    @(posedge clk);
    for (int p = 0; p < 5; p++) send(2, 3, PID, 60 + p);
    wait_drain(4'b0100, 150);
    chk("stats_pkt_cnt", {32'd0, pkt_cnt}, 64'd5);
    chk("stats_beat_cnt", {32'd0, beat_cnt}, 64'd15);
    @(posedge clk); #3;
    dut.pkt_cnt_q  = 32'hFFFF_FFFF;
    dut.beat_cnt_q = 32'hFFFF_FFFD;
    @(posedge clk);
    send(2, 3, PID, 70);
    wait_drain(4'b0100, 40);
    chk("stats_pkt_wrap", {32'd0, pkt_cnt}, 64'd0);
    chk("stats_beat_wrap", {32'd0, beat_cnt}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/egress_port.md
# egress_port

Per-output-port packet scheduler for the 4-port switch. It collects packet-start requests from the four ingress queues whose head beat targets this port and arbitrates among them with the round-robin `arbiter`. It then locks the winner for the whole packet and streams its beats through a registered valid/ready output stage to the egress link. There is one instance per output port.

## Interface
- `DATA_W`, 32: beat payload width.
- `PORT_ID`, 0: 2-bit index of this output port; used for destination match.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  4: ingress head beat valid, one bit per ingress port.
- `in_sop`  in  4: head beat is start of packet.
- `in_eop`  in  4: head beat is end of packet.
- `in_dest`  in  8: packed 2-bit destination per ingress port, `[2*i+1:2*i]`.
- `in_data`  in  4*DATA_W: packed head payload per ingress port.
- `in_ready`  out  4: pop strobe for the ingress head. At most one bit is high.
- `out_valid`  out  1: egress beat valid.
- `out_data`  out  DATA_W: egress payload.
- `out_sop`, `out_eop`  out  1 each: egress framing.
- `out_ready`  in  1: egress link accepts the beat.

## Operation
- Request vector: `req[i] = in_valid[i] & in_sop[i] & (in_dest[i] == PORT_ID)`.
- The request vector reaches the arbiter only in IDLE. It is forced to 0 in ARB and XFER, so the arbiter emits zero grants outside IDLE+1.
- FSM states:
  - IDLE: if any `req` bit is set, go to ARB; otherwise stay.
  - ARB: sample the arbiter grant. If it is nonzero, latch `sel` = index of the lowest set bit and go to XFER. If it is zero (requests withdrawn), return to IDLE.
  - XFER: `in_ready[sel] = !out_valid | out_ready`; all other `in_ready` bits are 0. A beat transfers when `in_valid[sel] & in_ready[sel]`. A transfer with `in_eop[sel]=1` returns the FSM to IDLE. Any other transfer stays in XFER.
- Output register behaviour:
  - On each transfer it loads `in_data`, `in_sop` and `in_eop` of `sel` and sets `out_valid`.
  - `out_valid` clears when `out_ready` is high with no new transfer in that cycle.
  - Full-throughput pass: with `out_ready` held high, one beat moves per cycle.
- The packet lock is absolute. No other ingress is served until EOP, regardless of its requests.
- `in_valid[sel]` low during XFER: wait, with no timeout.
- A single-beat packet (sop=eop=1): XFER lasts one transfer cycle.
- A non-SOP head beat while in IDLE is not requested and is never popped; the upstream queue owns that error.
- Round-robin fairness comes from the arbiter pointer. It advances only on cycles where a grant is issued.

## Timing
- Reset values:
  - FSM = IDLE, `sel` = 0.
  - `out_valid`, `out_sop`, `out_eop` = 0; `out_data` = 0.
  - `in_ready` = 0; arbiter pointer = 0.
- Arbitration overhead, for an SOP visible at cycle T:
  - T: IDLE, request asserted.
  - T+1: ARB, grant seen.
  - T+2: XFER, first `in_ready`.
  - T+3: first `out_valid`.
- Each beat takes one cycle from input transfer to `out_valid`.
- Inter-packet gap: EOP transfer at cycle E. IDLE at E+1, ARB at E+2, next XFER at E+3. The minimum bubble is therefore 2 cycles of no pop.
- `out_*` hold stable while `out_valid & !out_ready`.
- Reset asserted mid-packet: all state clears immediately. The partial packet is dropped downstream; upstream retains any beats it has not yet popped.

## Configuration
- `EGRESS_STATS_EN` defined:
  - Adds output `pkt_cnt` [31:0], which increments on each egress EOP handshake (`out_valid & out_ready & out_eop`).
  - Adds output `beat_cnt` [31:0], which increments on each egress handshake.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: neither port nor any counter logic exists. Behaviour is otherwise identical.

## Structure
- `switch_pkg` holds:
  - `NUM_PORTS` = 4 and `PORT_W` = 2.
  - The `egress_state_e` enum {IDLE, ARB, XFER}.
  - A `beat_t` struct {data, sop, eop} parameterised via `DATA_W` default.
- One sub-module: the existing round-robin `arbiter`, instanced as `u_arb`. It is fed the masked request vector and returns the registered grant.
- The FSM, select register, output register and optional counters live in `egress_port` itself.

## Test plan
- Single request: port 2 sends a 3-beat packet with dest=PORT_ID and `out_ready`=1. Required: first pop at T+2; beats D0, D1, D2 on `out_data` at T+3..T+5; sop on the first beat, eop on the last.
- Contention: ports 0–3 all hold 2-beat packets for this port. Required: service order 0, 1, 2, 3, then 0 again, with a 2-cycle bubble between packets.
- Backpressure: `out_ready` is low for 4 cycles in mid-packet. Required: `out_*` stable, `in_ready[sel]`=0 while `out_valid`, no lost or duplicated beat.
- Lock and mismatch: port 1 is mid-packet and port 0 raises an SOP. Required: port 0 is not popped until port 1's EOP. An SOP with dest≠PORT_ID is never granted.
- Withdrawal and reset: a request drops at ARB, leaving grant=0. Required: return to IDLE with no pop. Reset asserted mid-XFER forces `out_valid`=0 and IDLE in the same cycle.
- With `EGRESS_STATS_EN`: after 5 packets of 3 beats, `pkt_cnt`=5 and `beat_cnt`=15. Preload near 2^32−1 and confirm the counters wrap to 0.
